// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch, hazard and writeback inputs plus the ID/EX register outputs.
interface id_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic [31:0]     instr;
    logic [XLEN-1:0] pc_in;
    logic            flush;
    logic            ex_mem_read;
    logic [4:0]      ex_rd;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            stall;
    logic [XLEN-1:0] id_ex_pc;
    logic [XLEN-1:0] id_ex_rs1_val;
    logic [XLEN-1:0] id_ex_rs2_val;
    logic [XLEN-1:0] id_ex_imm;
    logic [4:0]      id_ex_rs1;
    logic [4:0]      id_ex_rs2;
    logic [4:0]      id_ex_rd;
    logic [4:0]      id_ex_alu_op;
    logic            id_ex_alu_src_a;
    logic            id_ex_alu_src_b;
    logic            id_ex_mem_read;
    logic            id_ex_mem_write;
    logic [2:0]      id_ex_mem_funct3;
    logic            id_ex_reg_write;
    logic [1:0]      id_ex_wb_sel;
    logic            id_ex_branch;
    logic            id_ex_jump;
    logic            id_ex_jump_r;
    logic            id_ex_illegal;

    modport master (
        output instr, pc_in, flush, ex_mem_read, ex_rd, wb_we, wb_rd, wb_data,
        input  stall, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm, id_ex_rs1,
               id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_alu_src_a, id_ex_alu_src_b,
               id_ex_mem_read, id_ex_mem_write, id_ex_mem_funct3, id_ex_reg_write,
               id_ex_wb_sel, id_ex_branch, id_ex_jump, id_ex_jump_r, id_ex_illegal
    );

    modport slave (
        input  instr, pc_in, flush, ex_mem_read, ex_rd, wb_we, wb_rd, wb_data,
        output stall, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm, id_ex_rs1,
               id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_alu_src_a, id_ex_alu_src_b,
               id_ex_mem_read, id_ex_mem_write, id_ex_mem_funct3, id_ex_reg_write,
               id_ex_wb_sel, id_ex_branch, id_ex_jump, id_ex_jump_r, id_ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32IM decode stage: register file, immediate/control decode, load-use stall, ID/EX register.
module id_stage #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_PASS_B = 5'd18;

    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [4:0]      alu_op;
        logic            alu_src_a;
        logic            alu_src_b;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      mem_funct3;
        logic            reg_write;
        logic [1:0]      wb_sel;
        logic            branch;
        logic            jump;
        logic            jump_r;
        logic            illegal;
    } id_ex_t;

    logic [XLEN-1:0] rf_q [32];
    id_ex_t          id_ex_q;
    id_ex_t          id_ex_d;
    id_ex_t          dec_c;
    logic            rs1_used_c;
    logic            rs2_used_c;
    logic            stall_c;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_f;
    logic [4:0]      rs1_f;
    logic [4:0]      rs2_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [XLEN-1:0] rs1_rd_c, rs2_rd_c;

    assign opcode = bus.instr[6:0];
    assign rd_f   = bus.instr[11:7];
    assign funct3 = bus.instr[14:12];
    assign rs1_f  = bus.instr[19:15];
    assign rs2_f  = bus.instr[24:20];
    assign funct7 = bus.instr[31:25];

    // Immediate formats, all sign-extended from instr[31]; shifts carry only the shamt
    assign imm_i  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_b  = {{(XLEN-13){bus.instr[31]}}, bus.instr[31], bus.instr[7],
                     bus.instr[30:25], bus.instr[11:8], 1'b0};
    assign imm_u  = {{(XLEN-32){bus.instr[31]}}, bus.instr[31:12], 12'b0};
    assign imm_j  = {{(XLEN-21){bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                     bus.instr[20], bus.instr[30:21], 1'b0};
    assign imm_sh = {{(XLEN-5){1'b0}}, bus.instr[24:20]};

    // Register reads: x0 is hardwired zero, a same-cycle writeback is forwarded
    assign rs1_rd_c = (rs1_f == 5'd0) ? '0 :
                      (bus.wb_we && bus.wb_rd == rs1_f) ? bus.wb_data : rf_q[rs1_f];
    assign rs2_rd_c = (rs2_f == 5'd0) ? '0 :
                      (bus.wb_we && bus.wb_rd == rs2_f) ? bus.wb_data : rf_q[rs2_f];

    // Instruction decode into the ID/EX bundle and operand-usage flags
    always_comb begin
        dec_c        = '0;
        dec_c.pc     = bus.pc_in;
        dec_c.alu_op = ALU_ADD;
        rs1_used_c   = 1'b0;
        rs2_used_c   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_c.imm = imm_u; dec_c.alu_op = ALU_PASS_B;
                dec_c.alu_src_b = 1'b1; dec_c.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_c.imm = imm_u; dec_c.alu_src_a = 1'b1;
                dec_c.alu_src_b = 1'b1; dec_c.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec_c.imm = imm_j; dec_c.alu_src_a = 1'b1; dec_c.alu_src_b = 1'b1;
                dec_c.reg_write = 1'b1; dec_c.wb_sel = WB_PC4; dec_c.jump = 1'b1;
            end
            OPC_JALR: begin
                dec_c.imm = imm_i; rs1_used_c = 1'b1; dec_c.alu_src_b = 1'b1;
                dec_c.reg_write = 1'b1; dec_c.wb_sel = WB_PC4; dec_c.jump_r = 1'b1;
                dec_c.illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_c.imm = imm_b; rs1_used_c = 1'b1; rs2_used_c = 1'b1;
                dec_c.alu_op = ALU_SUB; dec_c.branch = 1'b1; dec_c.mem_funct3 = funct3;
                dec_c.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_c.imm = imm_i; rs1_used_c = 1'b1; dec_c.alu_src_b = 1'b1;
                dec_c.mem_read = 1'b1; dec_c.reg_write = 1'b1; dec_c.wb_sel = WB_MEM;
                dec_c.mem_funct3 = funct3;
                dec_c.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_c.imm = imm_s; rs1_used_c = 1'b1; rs2_used_c = 1'b1;
                dec_c.alu_src_b = 1'b1; dec_c.mem_write = 1'b1; dec_c.mem_funct3 = funct3;
                dec_c.illegal = funct3[2] || (funct3 == 3'b011);
            end
            OPC_OPIMM: begin
                dec_c.imm = imm_i; rs1_used_c = 1'b1;
                dec_c.alu_src_b = 1'b1; dec_c.reg_write = 1'b1;
                case (funct3)
                    3'b000: dec_c.alu_op = ALU_ADD;
                    3'b010: dec_c.alu_op = ALU_SLT;
                    3'b011: dec_c.alu_op = ALU_SLTU;
                    3'b100: dec_c.alu_op = ALU_XOR;
                    3'b110: dec_c.alu_op = ALU_OR;
                    3'b111: dec_c.alu_op = ALU_AND;
                    3'b001: begin
                        dec_c.imm = imm_sh; dec_c.alu_op = ALU_SLL;
                        dec_c.illegal = (funct7 != F7_BASE);
                    end
                    default: begin
                        dec_c.imm = imm_sh;
                        dec_c.alu_op = bus.instr[30] ? ALU_SRA : ALU_SRL;
                        dec_c.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                rs1_used_c = 1'b1; rs2_used_c = 1'b1; dec_c.reg_write = 1'b1;
                if (funct7 == F7_MEXT) begin
                    dec_c.alu_op = ALU_MUL + 5'(funct3);
                end else if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  dec_c.alu_op = ALU_ADD;
                        3'b001:  dec_c.alu_op = ALU_SLL;
                        3'b010:  dec_c.alu_op = ALU_SLT;
                        3'b011:  dec_c.alu_op = ALU_SLTU;
                        3'b100:  dec_c.alu_op = ALU_XOR;
                        3'b101:  dec_c.alu_op = ALU_SRL;
                        3'b110:  dec_c.alu_op = ALU_OR;
                        default: dec_c.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_c.alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_c.alu_op = ALU_SRA;
                end else begin
                    dec_c.illegal = 1'b1;
                end
            end
            default: dec_c.illegal = 1'b1;
        endcase
        // Undecodable: keep only the PC and the illegal flag
        if (dec_c.illegal) begin
            dec_c         = '0;
            dec_c.pc      = bus.pc_in;
            dec_c.illegal = 1'b1;
            rs1_used_c    = 1'b0;
            rs2_used_c    = 1'b0;
        end
        // Unused register fields are zeroed so downstream forwarding never matches them
        dec_c.rd      = dec_c.reg_write ? rd_f : 5'd0;
        dec_c.rs1     = rs1_used_c ? rs1_f : 5'd0;
        dec_c.rs2     = rs2_used_c ? rs2_f : 5'd0;
        dec_c.rs1_val = rs1_used_c ? rs1_rd_c : '0;
        dec_c.rs2_val = rs2_used_c ? rs2_rd_c : '0;
    end

    // Load-use hazard against the load in EX; flush and reset suppress it
    assign stall_c = !rst && !bus.flush && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                     ((rs1_used_c && bus.ex_rd == rs1_f) || (rs2_used_c && bus.ex_rd == rs2_f));

    // Next ID/EX contents: bubble on flush, stall or the canonical NOP
    always_comb begin
        id_ex_d = dec_c;
        if (bus.flush || stall_c || bus.instr == NOP_INSTR) begin
            id_ex_d = '0;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) id_ex_q <= '0;
        else     id_ex_q <= id_ex_d;
    end

    // Architectural register file; writeback is independent of stall/flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (bus.wb_we && bus.wb_rd != 5'd0) begin
            rf_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign bus.stall            = stall_c;
    assign bus.id_ex_pc         = id_ex_q.pc;
    assign bus.id_ex_rs1_val    = id_ex_q.rs1_val;
    assign bus.id_ex_rs2_val    = id_ex_q.rs2_val;
    assign bus.id_ex_imm        = id_ex_q.imm;
    assign bus.id_ex_rs1        = id_ex_q.rs1;
    assign bus.id_ex_rs2        = id_ex_q.rs2;
    assign bus.id_ex_rd         = id_ex_q.rd;
    assign bus.id_ex_alu_op     = id_ex_q.alu_op;
    assign bus.id_ex_alu_src_a  = id_ex_q.alu_src_a;
    assign bus.id_ex_alu_src_b  = id_ex_q.alu_src_b;
    assign bus.id_ex_mem_read   = id_ex_q.mem_read;
    assign bus.id_ex_mem_write  = id_ex_q.mem_write;
    assign bus.id_ex_mem_funct3 = id_ex_q.mem_funct3;
    assign bus.id_ex_reg_write  = id_ex_q.reg_write;
    assign bus.id_ex_wb_sel     = id_ex_q.wb_sel;
    assign bus.id_ex_branch     = id_ex_q.branch;
    assign bus.id_ex_jump       = id_ex_q.jump;
    assign bus.id_ex_jump_r     = id_ex_q.jump_r;
    assign bus.id_ex_illegal    = id_ex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table through a scoreboard plus reset corner sequences.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_if #(.XLEN(32)) bus ();
    id_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] pc, r1v, r2v, imm;
        logic [4:0]  r1, r2, rd, op;
        logic        a, b, mr, mw;
        logic [2:0]  f3;
        logic        rw;
        logic [1:0]  wbs;
        logic        br, j, jr, ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr, pc;
        logic        flush, exmr;
        logic [4:0]  exrd;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbdata;
        logic        stall;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t E(input logic [31:0] pc, r1v, r2v, imm,
                               input int r1, r2, rd, op, a, b, mr, mw, f3, rw, wbs, br, j, jr, ill);
        return {pc, r1v, r2v, imm, 5'(r1), 5'(r2), 5'(rd), 5'(op), 1'(a), 1'(b), 1'(mr), 1'(mw),
                3'(f3), 1'(rw), 2'(wbs), 1'(br), 1'(j), 1'(jr), 1'(ill)};
    endfunction

    function automatic exp_t grab();
        return {bus.id_ex_pc, bus.id_ex_rs1_val, bus.id_ex_rs2_val, bus.id_ex_imm,
                bus.id_ex_rs1, bus.id_ex_rs2, bus.id_ex_rd, bus.id_ex_alu_op,
                bus.id_ex_alu_src_a, bus.id_ex_alu_src_b, bus.id_ex_mem_read, bus.id_ex_mem_write,
                bus.id_ex_mem_funct3, bus.id_ex_reg_write, bus.id_ex_wb_sel,
                bus.id_ex_branch, bus.id_ex_jump, bus.id_ex_jump_r, bus.id_ex_illegal};
    endfunction

    task automatic add(input logic [31:0] instr, pc, input int flush, exmr, exrd, wbwe, wbrd,
                       input logic [31:0] wbdata, input int stall, input exp_t e);
        vec_t v;
        v.instr = instr; v.pc = pc; v.flush = 1'(flush); v.exmr = 1'(exmr); v.exrd = 5'(exrd);
        v.wbwe = 1'(wbwe); v.wbrd = 5'(wbrd); v.wbdata = wbdata; v.stall = 1'(stall); v.e = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.instr = v.instr; bus.pc_in = v.pc; bus.flush = v.flush;
        bus.ex_mem_read = v.exmr; bus.ex_rd = v.exrd;
        bus.wb_we = v.wbwe; bus.wb_rd = v.wbrd; bus.wb_data = v.wbdata;
    endtask

    task automatic check_stall(input string name, input logic want);
        checks++;
        if (bus.stall !== want) begin
            failures++;
            $display("FAIL %s stall: got %b want %b", name, bus.stall, want);
        end
    endtask

    task automatic check_out(input string name);
        exp_t act, e;
        act = grab();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s id_ex: scoreboard empty, got %h", name, act);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL %s id_ex: got %h want %h", name, act, e);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        #1;
        check_stall(name, v.stall);
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    localparam logic [31:0] I_ADD_5_7 = 32'h00728333;
    localparam logic [31:0] I_ADDI_M1 = 32'hfff18213;
    localparam logic [31:0] I_LUI     = 32'h123450b7;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // instr, pc, flush, exmr, exrd, wbwe, wbrd, wbdata, stall, expected
        add(I_LUI,        32'h00, 0,0,0, 0,0,32'h0, 0, E(32'h00,0,0,32'h12345000, 0,0,1,18, 0,1,0,0,0,1,0,0,0,0,0));
        add(32'h00001117, 32'h04, 0,0,0, 0,0,32'h0, 0, E(32'h04,0,0,32'h00001000, 0,0,2,0, 1,1,0,0,0,1,0,0,0,0,0));
        add(I_ADDI_M1,    32'h08, 0,0,0, 1,3,32'hDEADBEEF, 0, E(32'h08,32'hDEADBEEF,0,32'hFFFFFFFF, 3,0,4,0, 0,1,0,0,0,1,0,0,0,0,0));
        add(32'h00518333, 32'h0c, 0,0,0, 1,5,32'h11, 0, E(32'h0c,32'hDEADBEEF,32'h11,0, 3,5,6,0, 0,0,0,0,0,1,0,0,0,0,0));
        add(32'h403284b3, 32'h10, 0,0,0, 1,0,32'h55, 0, E(32'h10,32'h11,32'hDEADBEEF,0, 5,3,9,1, 0,0,0,0,0,1,0,0,0,0,0));
        add(32'h00500333, 32'h14, 0,0,0, 0,0,32'h0, 0, E(32'h14,0,32'h11,0, 0,5,6,0, 0,0,0,0,0,1,0,0,0,0,0));
        add(32'h02a48433, 32'h18, 0,0,0, 0,0,32'h0, 0, E(32'h18,0,0,0, 9,10,8,10, 0,0,0,0,0,1,0,0,0,0,0));
        add(32'h0000007f, 32'h1c, 0,0,0, 0,0,32'h0, 0, E(32'h1c,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1));
        add(32'h0051a623, 32'h20, 0,0,0, 0,0,32'h0, 0, E(32'h20,32'hDEADBEEF,32'h11,32'h0000000c, 3,5,0,0, 0,1,0,1,2,0,0,0,0,0,0));
        add(32'hffc2a383, 32'h24, 0,0,0, 0,0,32'h0, 0, E(32'h24,32'h11,0,32'hFFFFFFFC, 5,0,7,0, 0,1,1,0,2,1,1,0,0,0,0));
        add(32'hfe208ce3, 32'h28, 0,0,0, 0,0,32'h0, 0, E(32'h28,0,0,32'hFFFFFFF8, 1,2,0,1, 0,0,0,0,0,0,0,1,0,0,0));
        add(32'h010000ef, 32'h2c, 0,0,0, 0,0,32'h0, 0, E(32'h2c,0,0,32'h10, 0,0,1,0, 1,1,0,0,0,1,2,0,1,0,0));
        add(32'h00008067, 32'h30, 0,0,0, 0,0,32'h0, 0, E(32'h30,0,0,0, 1,0,0,0, 0,1,0,0,0,1,2,0,0,1,0));
        add(32'h4041d193, 32'h34, 0,0,0, 0,0,32'h0, 0, E(32'h34,32'hDEADBEEF,0,32'h4, 3,0,3,7, 0,1,0,0,0,1,0,0,0,0,0));
        add(32'h00000013, 32'h38, 0,0,0, 0,0,32'h0, 0, '0);
        add(I_ADD_5_7,    32'h3c, 0,1,5, 0,0,32'h0, 1, '0);
        add(I_ADD_5_7,    32'h3c, 0,0,5, 0,0,32'h0, 0, E(32'h3c,32'h11,0,0, 5,7,6,0, 0,0,0,0,0,1,0,0,0,0,0));
        add(I_ADD_5_7,    32'h40, 1,1,5, 0,0,32'h0, 0, '0);
        add(I_ADD_5_7,    32'h40, 0,1,0, 0,0,32'h0, 0, E(32'h40,32'h11,0,0, 5,7,6,0, 0,0,0,0,0,1,0,0,0,0,0));
        add(I_ADD_5_7,    32'h44, 0,1,7, 0,0,32'h0, 1, '0);
        add(I_ADDI_M1,    32'h48, 0,1,31, 0,0,32'h0, 0, E(32'h48,32'hDEADBEEF,0,32'hFFFFFFFF, 3,0,4,0, 0,1,0,0,0,1,0,0,0,0,0));
        add(I_LUI,        32'h4c, 0,1,8, 0,0,32'h0, 0, E(32'h4c,0,0,32'h12345000, 0,0,1,18, 0,1,0,0,0,1,0,0,0,0,0));

        // Reset with a hazardous instruction present: no stall, all outputs clear
        rst = 1'b1;
        v = vecs[15];
        drive(v);
        #1;
        check_stall("reset_stall", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('0);
        check_out("reset_out");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-stall clears stall, ID/EX and the register file
        @(negedge clk);
        drive(vecs[15]);
        #1;
        check_stall("midstall_pre", 1'b1);
        rst = 1'b1;
        #1;
        check_stall("midstall_rst", 1'b0);
        sb.push_back('0);
        check_out("midstall_clear");
        @(negedge clk);
        rst = 1'b0;
        v = vecs[2];
        v.pc = 32'h100; v.exmr = 1'b0; v.wbwe = 1'b0;
        v.e = E(32'h100,0,0,32'hFFFFFFFF, 3,0,4,0, 0,1,0,0,0,1,0,0,0,0,0);
        apply(v, "post_reset_rf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
